ws2812b_pixel_feeder: RTL



---
 rtl/ws2812b_pixel_feeder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ws2812b_pixel_feeder.sv
// ws2812b_pixel_feeder
//   Double-buffered GRB frame store feeding the WS2812B bit encoder.
//   The write port fills the inactive bank; commit publishes it at the next
//   refresh tick. Once per refresh period the active bank is streamed
//   pixel by pixel over a valid/ready handshake.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data  pixel write into the inactive bank
//   commit              publish the inactive bank at the next frame start
//   pix_data/pix_valid/pix_ready/pix_last  pixel stream to the encoder
//   frame_start         one-cycle pulse when a frame begins
//   frame_overrun       one-cycle pulse when a tick lands mid-frame
module ws2812b_pixel_feeder #(
  parameter int unsigned LED_COUNT  = 24,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned REFRESH_HZ = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              commit,
  output logic [23:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              frame_start,
  output logic              frame_overrun
);

  localparam int unsigned PERIOD    = CLK_HZ / REFRESH_HZ;
  localparam int unsigned CNT_W     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned BUF_DEPTH = 2 ** (ADDR_W + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(PERIOD - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LED_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_VALID
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   index;
  logic                active_bank;
  logic                commit_pending;
  logic                armed;

  logic                tick_c;
  logic                pending_c;
  logic                armed_c;

  // Both banks in one array; the bank select is the address MSB.
  logic [23:0] mem [BUF_DEPTH];

  // A commit in the tick cycle counts for that tick.
  assign tick_c    = (cnt == CNT_MAX);
  assign pending_c = commit_pending | commit;
  assign armed_c   = armed | commit;

  // Write port: inactive bank only, out-of-range addresses dropped.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr <= LAST_IDX)) begin
      mem[{~active_bank, wr_addr}] <= wr_data;
    end
  end

  // Refresh timing, bank swap and pixel streaming.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      index          <= '0;
      active_bank    <= 1'b0;
      commit_pending <= 1'b0;
      armed          <= 1'b0;
      pix_data       <= '0;
      pix_valid      <= 1'b0;
      pix_last       <= 1'b0;
      frame_start    <= 1'b0;
      frame_overrun  <= 1'b0;
    end else begin
      frame_start    <= 1'b0;
      frame_overrun  <= 1'b0;
      cnt            <= tick_c ? '0 : cnt + CNT_W'(1);
      commit_pending <= pending_c;
      armed          <= armed_c;

      // A tick that lands mid-frame is dropped, pending commit kept.
      if (tick_c && (state != S_IDLE)) begin
        frame_overrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (tick_c && armed_c) begin
            if (pending_c) begin
              active_bank    <= ~active_bank;
              commit_pending <= 1'b0;
            end
            frame_start <= 1'b1;
            index       <= '0;
            state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          pix_data  <= mem[{active_bank, index}];
          pix_valid <= 1'b1;
          pix_last  <= (index == LAST_IDX);
          state     <= S_VALID;
        end
        S_VALID: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            if (pix_last) begin
              pix_last <= 1'b0;
              state    <= S_IDLE;
            end else begin
              index <= index + ADDR_W'(1);
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
